// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with press/release debounce and one-hot key code.
// Ports: clk, reset (sync, active-low), rows (in), cols, new_key, key_pressed_value.
module keypad_scanner #(
  parameter int SCAN_CYCLES     = 1000,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic        new_key,
  output logic [15:0] key_pressed_value
);

  localparam int DW = $clog2(SCAN_CYCLES);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_SCAN,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    meta_q, rows_s_q;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    cols_q, cols_d;
  logic          new_key_q, new_key_d;
  logic [15:0]   val_q, val_d;

  logic [3:0]    low;
  logic          one_low;
  logic [1:0]    row_idx;

  // Rows are active-low: a single pressed key in the driven column
  // shows up as exactly one low bit.
  assign low     = ~rows_s_q;
  assign one_low = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);

  always_comb begin
    case (low)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    pat_d     = pat_q;
    new_key_d = 1'b0;
    val_d     = val_q;
    case (state_q)
      S_SCAN: begin
        // Sample only at the end of the dwell so the synchronizer
        // has caught up with the newly driven column.
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (one_low) begin
            state_d = S_DEBOUNCE;
            row_d   = row_idx;
            pat_d   = rows_s_q;
            cnt_d   = '0;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (rows_s_q != pat_q) begin
          state_d = S_SCAN;
          dwell_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_HELD;
          new_key_d = 1'b1;
          val_d     = 16'd1 << {row_q, col_q};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HELD: begin
        if (rows_s_q[row_q]) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end
      end
      S_RELEASE: begin
        if (!rows_s_q[row_q]) begin
          state_d = S_HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_SCAN;
          col_d   = col_q + 2'd1;
          dwell_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_SCAN;
    endcase
    cols_d = ~(4'b0001 << col_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta_q    <= 4'hF;
      rows_s_q  <= 4'hF;
      state_q   <= S_SCAN;
      col_q     <= 2'd0;
      dwell_q   <= '0;
      cnt_q     <= '0;
      row_q     <= 2'd0;
      pat_q     <= 4'hF;
      cols_q    <= 4'b1110;
      new_key_q <= 1'b0;
      val_q     <= 16'h0000;
    end else begin
      meta_q    <= rows;
      rows_s_q  <= meta_q;
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      pat_q     <= pat_d;
      cols_q    <= cols_d;
      new_key_q <= new_key_d;
      val_q     <= val_d;
    end
  end

  assign cols              = cols_q;
  assign new_key           = new_key_q;
  assign key_pressed_value = val_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational keypad model.
// Ports driven: clk, reset, rows; observed: cols, new_key, key_pressed_value.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        new_key;
  logic [15:0] key_pressed_value;
  logic [15:0] keys;

  int tests;
  int fails;
  int pulses;

  keypad_scanner #(
    .SCAN_CYCLES(4),
    .DEBOUNCE_CYCLES(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .new_key(new_key),
    .key_pressed_value(key_pressed_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !cols[c]) rows[r] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (new_key) pulses++;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pulse(input int limit, output bit got);
    got = 0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      if (new_key) got = 1;
    end
  endtask

  task automatic test_reset;
    keys = 16'h0;
    reset = 1'b0;
    cycles(3);
    tests++;
    if (cols !== 4'b1110) begin
      fails++;
      $display("FAIL reset_cols got=%b exp=1110", cols);
    end
    tests++;
    if (new_key !== 1'b0) begin
      fails++;
      $display("FAIL reset_new_key got=%b exp=0", new_key);
    end
    tests++;
    if (key_pressed_value !== 16'h0000) begin
      fails++;
      $display("FAIL reset_value got=%h exp=0000", key_pressed_value);
    end
  endtask

  task automatic test_scan_idle;
    logic [3:0] exp_c [5];
    int base;
    exp_c[0] = 4'b1110;
    exp_c[1] = 4'b1101;
    exp_c[2] = 4'b1011;
    exp_c[3] = 4'b0111;
    exp_c[4] = 4'b1110;
    base = pulses;
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k != 0) cycles(4);
      tests++;
      if (cols !== exp_c[k]) begin
        fails++;
        $display("FAIL scan_cols[%0d] got=%b exp=%b", k, cols, exp_c[k]);
      end
    end
    tests++;
    if (pulses != base) begin
      fails++;
      $display("FAIL scan_no_pulse got=%0d exp=0", pulses - base);
    end
    tests++;
    if (key_pressed_value !== 16'h0000) begin
      fails++;
      $display("FAIL scan_value got=%h exp=0000", key_pressed_value);
    end
  endtask

  task automatic test_single_key;
    bit got;
    int base;
    base = pulses;
    keys = 16'h0040;
    wait_pulse(300, got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL single_pulse_seen got=0 exp=1");
    end
    tests++;
    if (key_pressed_value !== 16'h0040) begin
      fails++;
      $display("FAIL single_value got=%h exp=0040", key_pressed_value);
    end
    @(negedge clk);
    tests++;
    if (new_key !== 1'b0) begin
      fails++;
      $display("FAIL single_pulse_width got=%b exp=0", new_key);
    end
    cycles(30);
    tests++;
    if (pulses - base != 1) begin
      fails++;
      $display("FAIL single_pulse_count got=%0d exp=1", pulses - base);
    end
    keys = 16'h0;
    cycles(12);
    tests++;
    if (cols !== 4'b0111) begin
      fails++;
      $display("FAIL single_resume_col got=%b exp=0111", cols);
    end
    cycles(20);
  endtask

  task automatic test_bounce;
    bit got;
    int base;
    base = pulses;
    for (int i = 0; i < 20; i++) begin
      keys = ((i / 3) % 2 == 0) ? 16'h0200 : 16'h0000;
      @(negedge clk);
    end
    tests++;
    if (pulses != base) begin
      fails++;
      $display("FAIL bounce_window got=%0d exp=0", pulses - base);
    end
    keys = 16'h0200;
    wait_pulse(300, got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL bounce_pulse_seen got=0 exp=1");
    end
    tests++;
    if (key_pressed_value !== 16'h0200) begin
      fails++;
      $display("FAIL bounce_value got=%h exp=0200", key_pressed_value);
    end
    cycles(30);
    tests++;
    if (pulses - base != 1) begin
      fails++;
      $display("FAIL bounce_count got=%0d exp=1", pulses - base);
    end
    keys = 16'h0;
    cycles(30);
  endtask

  task automatic test_multi_hold;
    bit got;
    int base;
    base = pulses;
    keys = 16'h0001;
    wait_pulse(300, got);
    tests++;
    if (!got || key_pressed_value !== 16'h0001) begin
      fails++;
      $display("FAIL multi_first got=%0d/%h exp=1/0001",
               got, key_pressed_value);
    end
    keys = 16'h1001;
    cycles(40);
    tests++;
    if (pulses - base != 1) begin
      fails++;
      $display("FAIL multi_extra got=%0d exp=1", pulses - base);
    end
    tests++;
    if (key_pressed_value !== 16'h0001) begin
      fails++;
      $display("FAIL multi_hold_value got=%h exp=0001", key_pressed_value);
    end
    keys = 16'h0;
    cycles(30);
    keys = 16'h8000;
    wait_pulse(300, got);
    tests++;
    if (!got || key_pressed_value !== 16'h8000) begin
      fails++;
      $display("FAIL multi_next got=%0d/%h exp=1/8000",
               got, key_pressed_value);
    end
    cycles(10);
    keys = 16'h0;
    cycles(30);
  endtask

  task automatic test_two_rows;
    bit seen2;
    bit seen3;
    int base;
    base = pulses;
    keys = 16'h0440;
    seen2 = 0;
    seen3 = 0;
    for (int i = 0; i < 40 && !seen2; i++) begin
      @(negedge clk);
      if (cols == 4'b1011) seen2 = 1;
    end
    for (int i = 0; i < 8 && !seen3; i++) begin
      @(negedge clk);
      if (cols == 4'b0111) seen3 = 1;
    end
    tests++;
    if (!(seen2 && seen3)) begin
      fails++;
      $display("FAIL two_rows_advance got=%0d%0d exp=11", seen2, seen3);
    end
    cycles(40);
    tests++;
    if (pulses != base) begin
      fails++;
      $display("FAIL two_rows_no_pulse got=%0d exp=0", pulses - base);
    end
    tests++;
    if (key_pressed_value !== 16'h8000) begin
      fails++;
      $display("FAIL two_rows_value got=%h exp=8000", key_pressed_value);
    end
    keys = 16'h0;
    cycles(20);
  endtask

  task automatic test_release_bounce;
    bit got;
    bit seen;
    int base;
    base = pulses;
    keys = 16'h0002;
    wait_pulse(300, got);
    tests++;
    if (!got || key_pressed_value !== 16'h0002) begin
      fails++;
      $display("FAIL relb_first got=%0d/%h exp=1/0002",
               got, key_pressed_value);
    end
    cycles(10);
    keys = 16'h0;
    cycles(3);
    keys = 16'h0002;
    cycles(2);
    keys = 16'h0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (cols == 4'b1011) seen = 1;
    end
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL relb_resume got=0 exp=1");
    end
    cycles(20);
    tests++;
    if (pulses - base != 1) begin
      fails++;
      $display("FAIL relb_count got=%0d exp=1", pulses - base);
    end
  endtask

  task automatic test_reset_held;
    bit got;
    int base;
    keys = 16'h0002;
    wait_pulse(300, got);
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL rsth_first got=0 exp=1");
    end
    cycles(10);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (cols !== 4'b1110 || new_key !== 1'b0 ||
        key_pressed_value !== 16'h0000) begin
      fails++;
      $display("FAIL rsth_state got=%b/%b/%h exp=1110/0/0000",
               cols, new_key, key_pressed_value);
    end
    cycles(2);
    base = pulses;
    reset = 1'b1;
    wait_pulse(300, got);
    tests++;
    if (!got || key_pressed_value !== 16'h0002) begin
      fails++;
      $display("FAIL rsth_redetect got=%0d/%h exp=1/0002",
               got, key_pressed_value);
    end
    cycles(20);
    tests++;
    if (pulses - base != 1) begin
      fails++;
      $display("FAIL rsth_count got=%0d exp=1", pulses - base);
    end
    keys = 16'h0;
    cycles(20);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    pulses = 0;
    keys = 16'h0;
    reset = 1'b0;
    test_reset;
    test_scan_idle;
    test_single_key;
    test_bounce;
    test_multi_hold;
    test_two_rows;
    test_release_bounce;
    test_reset_held;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
